// File: rtl/upg_loader.sv
// upg_loader: turns a UART byte stream of segments into 32-bit writes to instruction ROM or data RAM.
// Build with UPG_CHECKSUM_EN defined to require a trailing XOR checksum byte after the 0xFF end marker.
module upg_loader (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_err_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
`ifdef UPG_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        target;
  logic [15:0] count;
  logic [13:0] index;
  logic [1:0]  byte_cnt;
  logic [23:0] partial;
  logic [15:0] hdr_count;
  logic        last_word;

`ifdef UPG_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign hdr_count = {rx_data, count[7:0]};
  assign last_word = (({2'b00, index} + 16'd1) == count);

  assign upg_done_o = (state == DONE);
  assign upg_err_o  = (state == ERR);
  assign busy_o     = (state != IDLE) && (state != DONE) && (state != ERR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data == 8'h00 || rx_data == 8'h01) begin
            state_nxt = HDR_LO;
          end else if (rx_data == 8'hFF) begin
`ifdef UPG_CHECKSUM_EN
            state_nxt = CHK;
`else
            state_nxt = DONE;
`endif
          end else begin
            state_nxt = ERR;
          end
        end
        HDR_LO: state_nxt = HDR_HI;
        HDR_HI: begin
          if (hdr_count == 16'd0) begin
            state_nxt = IDLE;
          end else if (hdr_count > 16'd16384) begin
            state_nxt = ERR;
          end else begin
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (byte_cnt == 2'd3 && last_word) begin
            state_nxt = IDLE;
          end
        end
`ifdef UPG_CHECKSUM_EN
        CHK: state_nxt = (rx_data == csum) ? DONE : ERR;
`endif
        default: state_nxt = state;
      endcase
    end
  end

  // The 4th byte goes straight into the output word, so the write strobe
  // lands one cycle later while the FSM is already free to take the next byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      target    <= 1'b0;
      count     <= 16'd0;
      index     <= 14'd0;
      byte_cnt  <= 2'd0;
      partial   <= 24'd0;
      upg_wen_o <= 1'b0;
      upg_adr_o <= 15'd0;
      upg_dat_o <= 32'd0;
    end else begin
      upg_wen_o <= 1'b0;
      if (rx_valid) begin
        case (state)
          IDLE:   target <= rx_data[0];
          HDR_LO: count[7:0] <= rx_data;
          HDR_HI: begin
            count[15:8] <= rx_data;
            index       <= 14'd0;
            byte_cnt    <= 2'd0;
          end
          DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: partial[7:0]   <= rx_data;
              2'd1: partial[15:8]  <= rx_data;
              2'd2: partial[23:16] <= rx_data;
              default: begin
                upg_wen_o <= 1'b1;
                upg_adr_o <= {target, index};
                upg_dat_o <= {rx_data, partial};
                index     <= index + 14'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UPG_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      csum <= 8'd0;
    end else if (rx_valid && (state == IDLE || state == HDR_LO ||
                              state == HDR_HI || state == DATA)) begin
      csum <= csum ^ rx_data;
    end
  end
`endif

endmodule

// File: tb/tb_upg_loader.sv
// Randomized and directed bench for upg_loader against a stream-parsing reference model.
module tb_upg_loader;

  logic        clock;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        upg_err_o;
  logic        busy_o;

  upg_loader dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .upg_wen_o  (upg_wen_o),
    .upg_adr_o  (upg_adr_o),
    .upg_dat_o  (upg_dat_o),
    .upg_done_o (upg_done_o),
    .upg_err_o  (upg_err_o),
    .busy_o     (busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  stim[$];
  logic [46:0] obs_q[$];
  logic [46:0] exp_q[$];
  logic        exp_done, exp_err, exp_busy;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (upg_wen_o) obs_q.push_back({upg_adr_o, upg_dat_o});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wen"},  64'(upg_wen_o),  64'd0);
    check({tag, "_adr"},  64'(upg_adr_o),  64'd0);
    check({tag, "_dat"},  64'(upg_dat_o),  64'd0);
    check({tag, "_done"}, 64'(upg_done_o), 64'd0);
    check({tag, "_err"},  64'(upg_err_o),  64'd0);
    check({tag, "_busy"}, 64'(busy_o),     64'd0);
  endtask

  // Reference model: parse the whole byte stream as segments and markers.
  task automatic model_run();
    int          p;
    int          cnt;
    bit          fin;
    logic [7:0]  t, cs;
    logic [31:0] w;
    exp_q.delete();
    exp_done = 0; exp_err = 0; exp_busy = 0;
    cs = 8'd0; p = 0; fin = 0;
    while (!fin && p < stim.size()) begin
      t = stim[p]; p++; cs ^= t; exp_busy = 1;
      if (t == 8'hFF) begin
`ifdef UPG_CHECKSUM_EN
        if (p < stim.size()) begin
          if (stim[p] == cs) exp_done = 1; else exp_err = 1;
          exp_busy = 0;
        end
`else
        exp_done = 1; exp_busy = 0;
`endif
        fin = 1;
      end else if (t > 8'h01) begin
        exp_err = 1; exp_busy = 0; fin = 1;
      end else begin
        if (p + 2 > stim.size()) break;
        cnt = int'({stim[p+1], stim[p]});
        cs ^= stim[p] ^ stim[p+1];
        p += 2;
        if (cnt == 0) begin
          exp_busy = 0;
        end else if (cnt > 16384) begin
          exp_err = 1; exp_busy = 0; fin = 1;
        end else begin
          for (int i = 0; i < cnt && !fin; i++) begin
            if (p + 4 > stim.size()) begin
              fin = 1;
            end else begin
              w = {stim[p+3], stim[p+2], stim[p+1], stim[p]};
              cs ^= stim[p] ^ stim[p+1] ^ stim[p+2] ^ stim[p+3];
              p += 4;
              exp_q.push_back({t[0], 14'(i), w});
            end
          end
          if (!fin) exp_busy = 0;
        end
      end
    end
  endtask

  function automatic logic [7:0] stream_xor();
    logic [7:0] x = 8'd0;
    foreach (stim[i]) x ^= stim[i];
    return x;
  endfunction

  task automatic do_reset();
    rx_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    obs_q.delete();
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic drive_stream(input bit gaps);
    foreach (stim[i]) begin
      send_byte(stim[i]);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic compare(input string name);
    int n;
    model_run();
    check($sformatf("%s_nwr", name), 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_adr%0d", name, i), 64'(obs_q[i][46:32]), 64'(exp_q[i][46:32]));
      check($sformatf("%s_dat%0d", name, i), 64'(obs_q[i][31:0]),  64'(exp_q[i][31:0]));
    end
    check($sformatf("%s_done", name), 64'(upg_done_o), 64'(exp_done));
    check($sformatf("%s_err", name),  64'(upg_err_o),  64'(exp_err));
    check($sformatf("%s_busy", name), 64'(busy_o),     64'(exp_busy));
  endtask

  task automatic run_case(input string name, input bit gaps);
    do_reset();
    drive_stream(gaps);
    compare(name);
  endtask

  task automatic gen_random();
    int nseg, r, cnt;
    stim.delete();
    nseg = $urandom_range(0, 3);
    for (int s = 0; s < nseg; s++) begin
      r = $urandom_range(0, 19);
      if (r == 0) stim.push_back(8'($urandom_range(2, 254)));
      else        stim.push_back(8'(r % 2));
      r = $urandom_range(0, 9);
      if (r == 0)      cnt = 0;
      else if (r == 1) cnt = 16385 + $urandom_range(0, 100);
      else             cnt = $urandom_range(1, 4);
      stim.push_back(cnt[7:0]);
      stim.push_back(cnt[15:8]);
      if (cnt <= 16384)
        for (int b = 0; b < 4 * cnt; b++) stim.push_back(8'($urandom));
    end
    if ($urandom_range(0, 7) != 0) begin
      stim.push_back(8'hFF);
`ifdef UPG_CHECKSUM_EN
      if ($urandom_range(0, 3) != 0) stim.push_back(stream_xor());
      else                           stim.push_back(8'($urandom));
`endif
    end else if (stim.size() > 0 && $urandom_range(0, 1) == 1) begin
      void'(stim.pop_back());
    end
    for (int b = 0; b < $urandom_range(0, 3); b++) stim.push_back(8'($urandom));
  endtask

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clock);
    check_reset_outputs("rst");
    reset = 1'b1;
    @(negedge clock);

    stim = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hFF};
`ifdef UPG_CHECKSUM_EN
    stim.push_back(stream_xor());
`endif
    run_case("two_words", 1);

    stim = '{8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_case("data_b2b", 0);

    do_reset();
    send_byte(8'h05);
    check("bad_type_err_next", 64'(upg_err_o), 64'd1);
    stim = '{8'h05, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
    for (int i = 1; i < stim.size(); i++) send_byte(stim[i]);
    repeat (3) @(negedge clock);
    compare("bad_type");

    stim = '{8'h00, 8'h01, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04};
    run_case("cnt_16385", 1);

    stim = '{8'h00, 8'h00, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04,
             8'h05, 8'h06, 8'h07, 8'h08};
    run_case("cnt_16384", 0);

    stim = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h03, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40,
             8'h00, 8'h01, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88, 8'hFF};
`ifdef UPG_CHECKSUM_EN
    stim.push_back(stream_xor());
`endif
    run_case("zero_and_rewrite", 1);

    do_reset();
    stim = '{8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
    drive_stream(0);
    check("mid_reset_nowr", 64'(obs_q.size()), 64'd0);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    obs_q.delete();
    stim = '{8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
`ifdef UPG_CHECKSUM_EN
    stim.push_back(stream_xor());
`endif
    drive_stream(1);
    compare("after_reset");

`ifdef UPG_CHECKSUM_EN
    stim = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
    stim.push_back(stream_xor());
    run_case("csum_good", 0);
    stim = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'h00};
    run_case("csum_bad", 0);
`endif

    for (int k = 0; k < 40; k++) begin
      gen_random();
      run_case($sformatf("rnd%0d", k), k[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
